// File: rtl/q_writeback.sv
// Q-value writeback stage: rescales pipeline sums, buffers them, writes the Q-table
// and forwards pending values. Define WB_SAT_EN to clamp out-of-range values instead of wrapping.
module q_writeback #(
  parameter int DW         = 24,
  parameter int QW         = 16,
  parameter int FRAC_SHIFT = 4,
  parameter int AW         = 8,
  parameter int DEPTH      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_sum,
  output logic          in_ready,
  input  logic          flush,
  output logic          flush_done,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [QW-1:0] mem_wr_data,
  input  logic          mem_ready,
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [QW-1:0] fwd_data,
  output logic [15:0]   wb_count,
  output logic          overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [QW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, fwd_idx;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  logic signed [DW-1:0] t;
  logic                 out_of_range;
  logic [QW-1:0]        conv;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && (state_q == RUN);
  assign push     = ce && in_valid && in_ready;
  assign pop      = !empty && mem_ready;

  // t fits QW bits only when bits [DW-1:QW-1] are a pure sign extension
  assign t            = $signed(in_sum) >>> FRAC_SHIFT;
  assign out_of_range = !(&t[DW-1:QW-1]) && (|t[DW-1:QW-1]);

`ifdef WB_SAT_EN
  always_comb begin
    conv = t[QW-1:0];
    if (out_of_range)
      conv = t[DW-1] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
  end
`else
  assign conv = t[QW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= conv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      wb_count     <= '0;
      overflow_err <= 1'b0;
      state_q      <= RUN;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (out_of_range) overflow_err <= 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        wb_count <= wb_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:   if (flush) state_d = DRAIN;
      DRAIN: if (empty) begin
        state_d    = RUN;
        flush_done = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign mem_wr_en   = !empty;
  assign mem_wr_addr = empty ? '0 : addr_mem[rd_ptr];
  assign mem_wr_data = empty ? '0 : data_mem[rd_ptr];

  // Scan oldest to youngest so the last match left standing is the newest value
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (addr_mem[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_q_writeback.sv
// Self-checking bench for q_writeback against a queue-based reference model.
module tb_q_writeback;

  localparam int DW = 24, QW = 16, FS = 4, AW = 8, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, ce, in_valid, flush, mem_ready;
  logic [AW-1:0] in_addr, fwd_addr, mem_wr_addr;
  logic [DW-1:0] in_sum;
  logic          in_ready, flush_done, mem_wr_en, fwd_hit, overflow_err;
  logic [QW-1:0] mem_wr_data, fwd_data;
  logic [15:0]   wb_count;

  always #5 clk = ~clk;

  q_writeback #(.DW(DW), .QW(QW), .FRAC_SHIFT(FS), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_addr(in_addr),
    .in_sum(in_sum), .in_ready(in_ready), .flush(flush), .flush_done(flush_done),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_ready(mem_ready), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .wb_count(wb_count), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [QW-1:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          draining;
  logic [15:0] m_wb;
  bit          m_ovf;
  int          checks = 0, failures = 0;

  // Floor-divide by 2^FS, then range-check / clamp / wrap with plain integer arithmetic
  function automatic logic [QW-1:0] ref_conv(input logic [DW-1:0] s, output bit ovf);
    longint v, q, lim;
    v   = longint'($signed(s));
    lim = longint'(1) << (QW - 1);
    if (v >= 0) q = v / (longint'(1) << FS);
    else        q = -((-v + (longint'(1) << FS) - 1) / (longint'(1) << FS));
    ovf = (q > lim - 1) || (q < -lim);
`ifdef WB_SAT_EN
    if (q > lim - 1) q = lim - 1;
    else if (q < -lim) q = -lim;
`endif
    return QW'(q);
  endfunction

  function automatic void model_fwd(input logic [AW-1:0] a, output bit hit, output logic [QW-1:0] d);
    hit = 0;
    d   = '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].addr == a) begin
        hit = 1;
        d   = mq[i].data;
        break;
      end
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !draining;
  endfunction

  task automatic model_reset();
    mq.delete();
    draining = 0;
    m_wb     = '0;
    m_ovf    = 0;
  endtask

  // Advances the model across one rising edge using the inputs stable before it
  task automatic advance();
    bit acc, pop, was_empty, ov;
    ent_t e;
    acc       = ce && in_valid && m_ready();
    pop       = (mq.size() != 0) && mem_ready;
    was_empty = (mq.size() == 0);
    e.addr    = in_addr;
    e.data    = ref_conv(in_sum, ov);
    @(posedge clk);
    if (pop) begin
      void'(mq.pop_front());
      m_wb = m_wb + 16'd1;
    end
    if (acc) begin
      mq.push_back(e);
      if (ov) m_ovf = 1;
    end
    if (!draining && flush) draining = 1;
    else if (draining && was_empty) draining = 0;
    #1;
  endtask

  function automatic logic [DW-1:0] fit_sum();
    logic [19:0] r;
    r = 20'($urandom);
    return {{4{r[19]}}, r};
  endfunction

  task automatic test_reset();
    rst = 1; ce = 0; in_valid = 0; in_addr = '0; in_sum = '0; flush = 0;
    mem_ready = 0; fwd_addr = '0;
    model_reset();
    #2;
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0b exp=0", mem_wr_en); end
    checks++; if (wb_count !== 16'd0) begin failures++; $display("FAIL rst_wb_count got=%0d exp=0", wb_count); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", overflow_err); end
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin failures++; $display("FAIL rst_fwd got=%0b/%0h exp=0/0", fwd_hit, fwd_data); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rst_flush_done got=%0b exp=0", flush_done); end
    checks++; if (mem_wr_addr !== '0 || mem_wr_data !== '0) begin failures++; $display("FAIL rst_wr_bus got=%0h/%0h exp=0/0", mem_wr_addr, mem_wr_data); end
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single_write();
    ce = 1; in_valid = 1; in_addr = 8'd5; in_sum = 24'h001234; mem_ready = 1;
    #3;
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL single_pre_wr_en got=%0b exp=0", mem_wr_en); end
    advance();
    in_valid = 0;
    #3;
    checks++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 8'd5 || mem_wr_data !== 16'h0123) begin
      failures++; $display("FAIL single_write got=%0b/%0h/%0h exp=1/5/123", mem_wr_en, mem_wr_addr, mem_wr_data); end
    advance();
    #3;
    checks++; if (mem_wr_en !== 1'b0 || wb_count !== 16'd1) begin
      failures++; $display("FAIL single_after got=%0b/%0d exp=0/1", mem_wr_en, wb_count); end
  endtask

  task automatic test_backpressure();
    logic [15:0] wb0;
    wb0 = m_wb;
    mem_ready = 0; ce = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_addr = AW'(i); in_sum = fit_sum();
      #3;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_%0d got=%0b exp=1", i, in_ready); end
      advance();
    end
    in_addr = 8'd5; in_sum = fit_sum();
    #3;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
    advance();
    in_valid = 0;
    mem_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      #3;
      checks++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== AW'(i) || mem_wr_data !== mq[0].data) begin
        failures++; $display("FAIL bp_write_%0d got=%0b/%0h/%0h exp=1/%0h/%0h", i, mem_wr_en, mem_wr_addr, mem_wr_data, i, mq[0].data); end
      advance();
    end
    #3;
    checks++; if (mem_wr_en !== 1'b0 || wb_count !== wb0 + 16'd4) begin
      failures++; $display("FAIL bp_done got=%0b/%0d exp=0/%0d", mem_wr_en, wb_count, wb0 + 16'd4); end
  endtask

  task automatic test_ce_gating();
    mem_ready = 0; ce = 0; in_valid = 1; in_addr = 8'd9; in_sum = fit_sum();
    advance();
    advance();
    #3;
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL ce_gate got=%0b exp=0", mem_wr_en); end
    ce = 1; in_valid = 0;
  endtask

  task automatic test_forwarding();
    mem_ready = 0; ce = 1; in_valid = 1;
    in_addr = 8'd7; in_sum = 24'h000010; advance();
    in_addr = 8'd7; in_sum = 24'h000020; advance();
    in_valid = 0; fwd_addr = 8'd7;
    #3;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'd2) begin failures++; $display("FAIL fwd_young got=%0b/%0h exp=1/2", fwd_hit, fwd_data); end
    fwd_addr = 8'd9;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'd0) begin failures++; $display("FAIL fwd_miss got=%0b/%0h exp=0/0", fwd_hit, fwd_data); end
    fwd_addr = 8'd7; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fwd_hit !== (i < 2) || fwd_data !== ((i < 2) ? 16'd2 : 16'd0)) begin
        failures++; $display("FAIL fwd_pop_%0d got=%0b/%0h exp=%0b/%0h", i, fwd_hit, fwd_data, i < 2, (i < 2) ? 2 : 0); end
      advance();
    end
  endtask

  task automatic test_saturation();
    logic [QW-1:0] e_hi, e_lo;
`ifdef WB_SAT_EN
    e_hi = 16'h7FFF; e_lo = 16'h8000;
`else
    e_hi = 16'hFFFF; e_lo = 16'h0000;
`endif
    #1;
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL sat_pre_ovf got=%0b exp=0", overflow_err); end
    mem_ready = 0; ce = 1; in_valid = 1;
    in_addr = 8'd1; in_sum = 24'h7FFFFF; advance();
    in_addr = 8'd2; in_sum = 24'h800000; advance();
    in_valid = 0; mem_ready = 1;
    #3;
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", overflow_err); end
    checks++; if (mem_wr_data !== e_hi) begin failures++; $display("FAIL sat_hi got=%0h exp=%0h", mem_wr_data, e_hi); end
    advance();
    #3;
    checks++; if (mem_wr_data !== e_lo) begin failures++; $display("FAIL sat_lo got=%0h exp=%0h", mem_wr_data, e_lo); end
    advance();
  endtask

  task automatic test_flush();
    mem_ready = 0; ce = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_addr = AW'(20 + i); in_sum = fit_sum(); advance();
    end
    in_valid = 0; flush = 1;
    advance();
    flush = 0;
    #3;
    checks++; if (in_ready !== 1'b0 || flush_done !== 1'b0) begin failures++; $display("FAIL flush_drain got=%0b/%0b exp=0/0", in_ready, flush_done); end
    mem_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      #3;
      checks++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== AW'(20 + i) || flush_done !== 1'b0) begin
        failures++; $display("FAIL flush_write_%0d got=%0b/%0h/%0b exp=1/%0h/0", i, mem_wr_en, mem_wr_addr, flush_done, 20 + i); end
      advance();
    end
    flush = 0; in_valid = 0;
    #3;
    checks++; if (flush_done !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL flush_done got=%0b/%0b exp=1/0", flush_done, in_ready); end
    advance();
    #3;
    checks++; if (flush_done !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_end got=%0b/%0b exp=0/1", flush_done, in_ready); end
    flush = 1;
    advance();
    flush = 0;
    #3;
    checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b exp=1", flush_done); end
    advance();
    #3;
    checks++; if (flush_done !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty_end got=%0b/%0b exp=0/1", flush_done, in_ready); end
  endtask

  task automatic test_async_reset();
    mem_ready = 0; ce = 1; in_valid = 1;
    in_addr = 8'd3; in_sum = 24'h7FFFFF; advance();
    in_addr = 8'd4; in_sum = fit_sum(); advance();
    in_valid = 0; fwd_addr = 8'd3;
    #3;
    checks++; if (overflow_err !== 1'b1 || mem_wr_en !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0b/%0b exp=1/1", overflow_err, mem_wr_en); end
    #1 rst = 1;
    #1;
    checks++; if (mem_wr_en !== 1'b0 || wb_count !== 16'd0 || overflow_err !== 1'b0 || fwd_hit !== 1'b0) begin
      failures++; $display("FAIL arst_now got=%0b/%0d/%0b/%0b exp=0/0/0/0", mem_wr_en, wb_count, overflow_err, fwd_hit); end
    model_reset();
    @(posedge clk); #1;
    rst = 0; mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL arst_stale_%0d got=%0b exp=0", i, mem_wr_en); end
      advance();
    end
  endtask

  task automatic test_random();
    bit            e_hit;
    logic [QW-1:0] e_fd;
    for (int c = 0; c < 400; c++) begin
      ce        = ($urandom_range(0, 7) != 0);
      in_valid  = $urandom_range(0, 1);
      in_addr   = AW'($urandom_range(0, 7));
      in_sum    = ($urandom_range(0, 15) == 0) ? DW'($urandom) : fit_sum();
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      fwd_addr  = AW'($urandom_range(0, 8));
      #3;
      model_fwd(fwd_addr, e_hit, e_fd);
      checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, in_ready, m_ready()); end
      checks++; if (mem_wr_en !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_wr_en c=%0d got=%0b exp=%0b", c, mem_wr_en, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (mem_wr_addr !== mq[0].addr || mem_wr_data !== mq[0].data) begin
          failures++; $display("FAIL rnd_wr_bus c=%0d got=%0h/%0h exp=%0h/%0h", c, mem_wr_addr, mem_wr_data, mq[0].addr, mq[0].data); end
      end
      checks++; if (fwd_hit !== e_hit || fwd_data !== e_fd) begin failures++; $display("FAIL rnd_fwd c=%0d got=%0b/%0h exp=%0b/%0h", c, fwd_hit, fwd_data, e_hit, e_fd); end
      checks++; if (flush_done !== (draining && mq.size() == 0)) begin failures++; $display("FAIL rnd_flush_done c=%0d got=%0b exp=%0b", c, flush_done, draining && mq.size() == 0); end
      checks++; if (wb_count !== m_wb || overflow_err !== m_ovf) begin failures++; $display("FAIL rnd_cnt_ovf c=%0d got=%0d/%0b exp=%0d/%0b", c, wb_count, overflow_err, m_wb, m_ovf); end
      advance();
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_ce_gating();
    test_forwarding();
    test_saturation();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_writeback.md
Name: q_writeback

Overview:
- Downstream neighbour of the Q-update `pipeline` stage.
- Consumes each updated Q value (DW-bit `sum`) with its table address and rescales it to the stored Q format (arithmetic shift right, then saturate or wrap).
- Buffers results in a small FIFO and writes them into the Q-table memory through a valid/ready write port.
- Provides a forwarding lookup so upstream reads of a not-yet-written address get the newest pending value (RAW hazard avoidance).

Parameters:
- DW, 24, input sum width (signed two's complement)
- QW, 16, stored Q-value width (signed)
- FRAC_SHIFT, 4, arithmetic right shift applied to sum before narrowing
- AW, 8, Q-table address width
- DEPTH, 4, write-buffer entries (power of 2, >=2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ce  in  1  clock enable from pipeline; gates input acceptance only
- in_valid  in  1  sum/addr valid
- in_addr  in  AW  Q-table address of the update
- in_sum  in  DW  updated Q value from pipeline
- in_ready  out  1  buffer can accept
- flush  in  1  one-cycle request to drain the buffer
- flush_done  out  1  one-cycle pulse when a drain completes
- mem_wr_en  out  1  write request to Q-table
- mem_wr_addr  out  AW  write address
- mem_wr_data  out  QW  write data
- mem_ready  in  1  memory accepts the write this cycle
- fwd_addr  in  AW  forwarding lookup address
- fwd_hit  out  1  a pending entry matches fwd_addr
- fwd_data  out  QW  youngest matching pending value
- wb_count  out  16  completed writes, wraps at 2^16
- overflow_err  out  1  sticky: a rescaled value did not fit QW

Behaviour:
- Reset (async, immediate): FIFO emptied, state RUN, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, fwd_hit=0, fwd_data=0, flush_done=0, wb_count=0, overflow_err=0. in_ready=1 once rst is low.
- Reset mid-operation: pending entries are discarded and no write is issued for them.
- Accept: push when ce & in_valid & in_ready; the entry stores in_addr and the converted value. With ce=0, in_valid is ignored.
- Conversion: t = in_sum >>> FRAC_SHIFT (sign-preserving). If t lies outside [-2^(QW-1), 2^(QW-1)-1], the value is out of range: set overflow_err (stays set until rst) and narrow per the optional feature.
- in_ready = !full && state==RUN. No push-through when full.
- Write port: mem_wr_en = !empty. mem_wr_addr/mem_wr_data = head entry, held stable while mem_ready=0.
- Pop: on mem_wr_en & mem_ready; wb_count increments on each pop.
- Latency: a value accepted at edge N with the FIFO empty shows mem_wr_en=1 in cycle N+1.
- Simultaneous push and pop: legal whenever not full; occupancy unchanged.
- Forwarding (combinational): fwd_hit=1 if any valid entry's addr==fwd_addr; fwd_data is the youngest such entry, 0 when no hit. The entry being popped this cycle still counts as a hit.
- FSM, RUN -> DRAIN: on flush=1. In DRAIN, in_ready=0 and pops continue.
- FSM, DRAIN -> RUN: when the FIFO is empty; flush_done pulses high for exactly one cycle on that transition.
- Flush with an empty FIFO: flush_done pulses on the following cycle.
- flush while already in DRAIN: ignored.

Optional Feature:
- WB_SAT_EN defined: out-of-range values clamp to 2^(QW-1)-1 or -2^(QW-1).
- Not defined: keep the low QW bits of t (wrap).
- overflow_err is set in both builds.

Test Plan:
- Single write: rst pulse, mem_ready=1, ce=1, in_addr=5, in_sum=24'h001234 -> next cycle mem_wr_en=1, mem_wr_addr=5, mem_wr_data=16'h0123; mem_wr_en=0 the cycle after; wb_count=1.
- Backpressure and ce gating: mem_ready=0, push addrs 1..4 -> in_ready=0. A 5th valid is not accepted. A valid with ce=0 is ignored. Raise mem_ready -> 4 writes in order 1,2,3,4 on 4 consecutive cycles; wb_count=4.
- Forwarding: mem_ready=0, push addr 7 sum 24'h000010 (->1), then addr 7 sum 24'h000020 (->2) -> fwd_addr=7 gives fwd_hit=1, fwd_data=2. fwd_addr=9 gives fwd_hit=0, fwd_data=0.
- Saturation: in_sum=24'h7FFFFF -> data 16'h7FFF with WB_SAT_EN, 16'hFFFF without. in_sum=24'h800000 -> 16'h8000 (SAT) or 16'h0000 (wrap). overflow_err=1 in both builds.
- Flush: mem_ready=0, push 3 entries, pulse flush -> in_ready=0. Raise mem_ready -> 3 writes, then flush_done high for one cycle, then in_ready=1.
- Async reset: 2 entries pending, overflow_err=1, rst raised between edges -> mem_wr_en=0, wb_count=0, overflow_err=0 immediately. After release, no stale writes are issued.
